// File: rtl/fetch_unit_pkg.sv
// Shared constants and helpers for the instruction-fetch front end.
// Instruction width, reset PC, bubble word and fetch-address width live here.
package fetch_unit_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned IMEM_AW = 9;

    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_WORD_DEF = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_INCR      = 32'd4;

    // Branch targets are forced onto a word boundary before they reach nPC.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage : fetch_unit_pkg

// File: rtl/fetch_unit_if.sv
// Bundle between the fetch unit and its neighbours: decode control, imem and IF/ID.
// master = fetch_unit side, slave = decode / memory / observer side.
interface fetch_unit_if
    import fetch_unit_pkg::*;
    ;

    logic                stall;
    logic                br_valid;
    logic                br_taken;
    logic                br_annul;
    logic [XLEN-1:0]     br_target;
    logic [IMEM_AW-1:0]  imem_addr;
    logic [XLEN-1:0]     imem_data;
    logic [XLEN-1:0]     pc_out;
    logic [XLEN-1:0]     npc_out;
    logic [XLEN-1:0]     ifid_instr;
    logic [XLEN-1:0]     ifid_pc;
    logic                ifid_valid;
    logic [XLEN-1:0]     fetch_count;

    modport master (
        input  stall, br_valid, br_taken, br_annul, br_target, imem_data,
        output imem_addr, pc_out, npc_out, ifid_instr, ifid_pc, ifid_valid, fetch_count
    );

    modport slave (
        output stall, br_valid, br_taken, br_annul, br_target, imem_data,
        input  imem_addr, pc_out, npc_out, ifid_instr, ifid_pc, ifid_valid, fetch_count
    );

endinterface : fetch_unit_if

// File: rtl/fetch_pc_pair.sv
// PC/nPC register pair with delayed-branch semantics: pc always takes the old nPC,
// so the delay slot is fetched; a taken redirect only rewrites nPC.
module fetch_pc_pair
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] target_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] npc_o
);

    logic [XLEN-1:0] pc_d,  pc_q;
    logic [XLEN-1:0] npc_d, npc_q;

    always_comb begin
        // NOTE: defaults first so every path assigns pc_d/npc_d and no latch is inferred.
        pc_d  = pc_q;
        npc_d = npc_q;
        if (!stall_i) begin
            pc_d  = npc_q;
            npc_d = redirect_i ? align_word(target_i) : npc_q + PC_INCR;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so both registers sample pre-edge values, as real flops do.
        if (reset) begin
            pc_q  <= RESET_PC;
            npc_q <= RESET_PC + PC_INCR;
        end else begin
            pc_q  <= pc_d;
            npc_q <= npc_d;
        end
    end

    assign pc_o  = pc_q;
    assign npc_o = npc_q;

endmodule : fetch_pc_pair

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: drives imem from the PC pair and latches the fetched
// word into IF/ID, with stall hold, delay-slot annul and a valid-fetch counter.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [XLEN-1:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
    logic            redirect;
    logic            squash;

    logic [XLEN-1:0] ifid_instr_d, ifid_instr_q;
    logic [XLEN-1:0] ifid_pc_d,    ifid_pc_q;
    logic            ifid_valid_d, ifid_valid_q;
    logic [XLEN-1:0] count_d,      count_q;

    assign redirect = bus.br_valid & bus.br_taken;
    // Only an untaken annulling branch kills its delay slot.
    assign squash   = bus.br_valid & ~bus.br_taken & bus.br_annul;

    fetch_pc_pair #(
        .RESET_PC (RESET_PC)
    ) u_pc_pair (
        .clk        (clk),
        .reset      (reset),
        .stall_i    (bus.stall),
        .redirect_i (redirect),
        .target_i   (bus.br_target),
        .pc_o       (pc),
        .npc_o      (npc)
    );

    always_comb begin
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_valid_d = ifid_valid_q;
        count_d      = count_q;
        if (!bus.stall) begin
            ifid_pc_d = pc;
            if (squash) begin
                ifid_instr_d = NOP_WORD;
                ifid_valid_d = 1'b0;
            end else begin
                ifid_instr_d = bus.imem_data;
                ifid_valid_d = 1'b1;
                count_d      = count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ifid_instr_q <= NOP_WORD;
            ifid_pc_q    <= '0;
            ifid_valid_q <= 1'b0;
            count_q      <= '0;
        end else begin
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_valid_q <= ifid_valid_d;
            count_q      <= count_d;
        end
    end

    assign bus.imem_addr   = pc[IMEM_AW-1:0];
    assign bus.pc_out      = pc;
    assign bus.npc_out     = npc;
    assign bus.ifid_instr  = ifid_instr_q;
    assign bus.ifid_pc     = ifid_pc_q;
    assign bus.ifid_valid  = ifid_valid_q;
    assign bus.fetch_count = count_q;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, stall, taken/untaken/annul branches,
// address wrap and reset override, against hand-computed expectations.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory model: word at byte address A is 32'hA500_0000 ^ A.
    function automatic logic [31:0] word_at(input logic [31:0] addr);
        return 32'hA500_0000 ^ {addr[31:2], 2'b00};
    endfunction

    assign bus.imem_data = word_at({23'd0, bus.imem_addr});

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.stall     = 1'b0;
        bus.br_valid  = 1'b0;
        bus.br_taken  = 1'b0;
        bus.br_annul  = 1'b0;
        bus.br_target = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        idle_inputs();

        // Reset state
        do_reset();
        check("rst_pc",    bus.pc_out,      32'h0);
        check("rst_npc",   bus.npc_out,     32'h4);
        check("rst_valid", {31'd0, bus.ifid_valid}, 32'd0);
        check("rst_instr", bus.ifid_instr,  32'h0);
        check("rst_ifpc",  bus.ifid_pc,     32'h0);
        check("rst_cnt",   bus.fetch_count, 32'd0);
        check("rst_iaddr", {23'd0, bus.imem_addr}, 32'h0);

        // Three free-running fetches
        for (int i = 0; i < 3; i++) begin
            tick();
            check("seq_instr", bus.ifid_instr, word_at(32'(i * 4)));
            check("seq_ifpc",  bus.ifid_pc,    32'(i * 4));
            check("seq_valid", {31'd0, bus.ifid_valid}, 32'd1);
        end
        check("seq_pc",  bus.pc_out,      32'd12);
        check("seq_npc", bus.npc_out,     32'd16);
        check("seq_cnt", bus.fetch_count, 32'd3);

        // Stall holds everything for two edges, then W2 loads
        do_reset();
        tick(); tick();
        bus.stall    = 1'b1;
        bus.br_valid = 1'b1;
        bus.br_taken = 1'b1;
        bus.br_target = 32'h80;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("stl_pc",    bus.pc_out,      32'd8);
            check("stl_npc",   bus.npc_out,     32'd12);
            check("stl_instr", bus.ifid_instr,  word_at(32'd4));
            check("stl_cnt",   bus.fetch_count, 32'd2);
        end
        idle_inputs();
        tick();
        check("rel_instr", bus.ifid_instr,  word_at(32'd8));
        check("rel_ifpc",  bus.ifid_pc,     32'd8);
        check("rel_cnt",   bus.fetch_count, 32'd3);
        check("rel_pc",    bus.pc_out,      32'd12);

        // Taken branch at pc=8 to 0x40: delay slot at 12 still fetched
        do_reset();
        tick(); tick();
        bus.br_valid  = 1'b1;
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h40;
        tick();
        check("tk_pc",    bus.pc_out,     32'd12);
        check("tk_npc",   bus.npc_out,    32'h40);
        check("tk_instr", bus.ifid_instr, word_at(32'd8));
        idle_inputs();
        tick();
        check("tk_pc2",   bus.pc_out,     32'h40);
        check("tk_npc2",  bus.npc_out,    32'h44);
        check("ds_instr", bus.ifid_instr, word_at(32'd12));
        check("ds_ifpc",  bus.ifid_pc,    32'd12);
        tick();
        check("tgt_instr", bus.ifid_instr,  word_at(32'h40));
        check("tgt_ifpc",  bus.ifid_pc,     32'h40);
        check("tgt_cnt",   bus.fetch_count, 32'd5);

        // Untaken annulling branch squashes the delay slot
        do_reset();
        tick(); tick();
        bus.br_valid = 1'b1;
        bus.br_annul = 1'b1;
        tick();
        check("an_valid", {31'd0, bus.ifid_valid}, 32'd0);
        check("an_instr", bus.ifid_instr,  32'h0);
        check("an_ifpc",  bus.ifid_pc,     32'd8);
        check("an_cnt",   bus.fetch_count, 32'd2);
        check("an_pc",    bus.pc_out,      32'd12);
        check("an_npc",   bus.npc_out,     32'd16);

        // Taken with annul does not squash; target low bits are dropped
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h43;
        tick();
        check("tka_valid", {31'd0, bus.ifid_valid}, 32'd1);
        check("tka_instr", bus.ifid_instr,  word_at(32'd12));
        check("tka_cnt",   bus.fetch_count, 32'd3);
        check("tka_npc",   bus.npc_out,     32'h40);
        idle_inputs();
        tick();
        check("tka_pc2",   bus.pc_out,      32'h40);

        // imem_addr wraps at pc=0x200
        do_reset();
        bus.br_valid  = 1'b1;
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h1FC;
        tick();
        idle_inputs();
        check("wr_npc",  bus.npc_out, 32'h1FC);
        tick();
        check("wr_pc",   bus.pc_out,  32'h1FC);
        check("wr_ia1",  {23'd0, bus.imem_addr}, 32'h1FC);
        tick();
        check("wr_pc2",  bus.pc_out,  32'h200);
        check("wr_ia2",  {23'd0, bus.imem_addr}, 32'h0);
        check("wr_ins1", bus.ifid_instr, word_at(32'h1FC));
        tick();
        check("wr_ins2", bus.ifid_instr, word_at(32'h0));
        check("wr_ifpc", bus.ifid_pc,    32'h200);

        // nPC+4 wraps modulo 2^32
        bus.br_valid  = 1'b1;
        bus.br_taken  = 1'b1;
        bus.br_target = 32'hFFFF_FFFC;
        tick();
        idle_inputs();
        tick();
        check("w32_pc",  bus.pc_out,  32'hFFFF_FFFC);
        check("w32_npc", bus.npc_out, 32'h0);
        check("w32_ia",  {23'd0, bus.imem_addr}, 32'h1FC);

        // Reset overrides stall and branch in the same edge
        bus.stall     = 1'b1;
        bus.br_valid  = 1'b1;
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h80;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("ro_pc",    bus.pc_out,      32'h0);
        check("ro_npc",   bus.npc_out,     32'h4);
        check("ro_valid", {31'd0, bus.ifid_valid}, 32'd0);
        check("ro_cnt",   bus.fetch_count, 32'd0);
        idle_inputs();
        tick();
        check("ro_instr", bus.ifid_instr,  word_at(32'h0));
        check("ro_cnt1",  bus.fetch_count, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fetch_unit
